// File: rtl/hb_decim2.sv
// hb_decim2: 11-tap halfband FIR with decimate-by-2, one folded multiplier, 4 MAC cycles per output.
// Optional macro HB_SAT_EN: clamp the rounded result to OUT_W (otherwise it wraps).
module hb_decim2 #(
    parameter int IN_W     = 32'sd64,
    parameter int IN_SHIFT = 32'sd40,
    parameter int DATA_W   = 32'sd24,
    parameter int COEF_W   = 32'sd18,
    parameter int OUT_W    = 32'sd24,
    parameter int COEF0    = 32'sd762,
    parameter int COEF2    = -32'sd5488,
    parameter int COEF4    = 32'sd37494,
    parameter int COEFC    = 32'sd65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int PRE_W = DATA_W + 32'sd1;
    localparam int ACC_W = DATA_W + COEF_W + 32'sd3;
    localparam int FRAC  = COEF_W - 32'sd1;
    localparam int R_W   = ACC_W - FRAC;

    localparam logic signed [IN_W-1:0]   X_MAX = {{(IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0]   X_MIN = {{(IN_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  HALF  = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [COEF_W-1:0] C0    = COEF_W'(COEF0);
    localparam logic signed [COEF_W-1:0] C2    = COEF_W'(COEF2);
    localparam logic signed [COEF_W-1:0] C4    = COEF_W'(COEF4);
    localparam logic signed [COEF_W-1:0] CC    = COEF_W'(COEFC);
`ifdef HB_SAT_EN
    localparam logic signed [R_W-1:0]    R_MAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0]    R_MIN = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC0  = 3'd1,
        ST_MAC1  = 3'd2,
        ST_MAC2  = 3'd3,
        ST_MACC  = 3'd4,
        ST_ROUND = 3'd5
    } state_e;

    function automatic logic signed [DATA_W-1:0] cond_in(input logic signed [IN_W-1:0] v);
        logic signed [IN_W-1:0] sh;
        sh = v >>> IN_SHIFT;
        if (sh > X_MAX) begin
            cond_in = DATA_W'(X_MAX);
        end else if (sh < X_MIN) begin
            cond_in = DATA_W'(X_MIN);
        end else begin
            cond_in = DATA_W'(sh);
        end
    endfunction

    function automatic logic [OUT_W-1:0] conv_out(input logic signed [R_W-1:0] r);
`ifdef HB_SAT_EN
        if (r > R_MAX) begin
            conv_out = OUT_W'(R_MAX);
        end else if (r < R_MIN) begin
            conv_out = OUT_W'(R_MIN);
        end else begin
            conv_out = OUT_W'(r);
        end
`else
        conv_out = OUT_W'(r);
`endif
    endfunction

    state_e                    state_r, state_next_s;
    logic signed [DATA_W-1:0]  dly_r [0:10];
    logic                      phase_r;
    logic signed [ACC_W-1:0]   acc_r, acc_next_s, prod_s, rnd_sum_s;
    logic signed [PRE_W-1:0]   pre_s;
    logic signed [COEF_W-1:0]  coef_s;
    logic signed [R_W-1:0]     r_s;
    logic [OUT_W-1:0]          conv_s;
    logic                      accept_s, start_s;
    logic [OUT_W-1:0]          out_data_r;
    logic                      out_valid_r, busy_r, overrun_r;

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

    // Next-state logic: a start fires on every second accepted sample.
    always_comb begin
        state_next_s = state_r;
        accept_s     = in_valid && (state_r == ST_IDLE);
        start_s      = accept_s && phase_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_MAC0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MAC0:  state_next_s = ST_MAC1;
            ST_MAC1:  state_next_s = ST_MAC2;
            ST_MAC2:  state_next_s = ST_MACC;
            ST_MACC:  state_next_s = ST_ROUND;
            ST_ROUND: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Folded MAC: symmetric taps are pre-added so one multiplier serves two taps.
    always_comb begin
        pre_s  = {PRE_W{1'b0}};
        coef_s = {COEF_W{1'b0}};
        case (state_r)
            ST_MAC0: begin pre_s = PRE_W'(dly_r[0]) + PRE_W'(dly_r[10]); coef_s = C0; end
            ST_MAC1: begin pre_s = PRE_W'(dly_r[2]) + PRE_W'(dly_r[8]);  coef_s = C2; end
            ST_MAC2: begin pre_s = PRE_W'(dly_r[4]) + PRE_W'(dly_r[6]);  coef_s = C4; end
            ST_MACC: begin pre_s = PRE_W'(dly_r[5]);                     coef_s = CC; end
            default: begin pre_s = {PRE_W{1'b0}};                        coef_s = {COEF_W{1'b0}}; end
        endcase
        prod_s = ACC_W'(pre_s) * ACC_W'(coef_s);
        if (state_r == ST_MAC0) begin
            acc_next_s = prod_s;
        end else if ((state_r == ST_MAC1) || (state_r == ST_MAC2) || (state_r == ST_MACC)) begin
            acc_next_s = acc_r + prod_s;
        end else begin
            acc_next_s = acc_r;
        end
        rnd_sum_s = acc_r + HALF;
        r_s       = R_W'(rnd_sum_s >>> FRAC);
        conv_s    = conv_out(r_s);
    end

    // State, delay line, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < 11; i++) dly_r[i] <= {DATA_W{1'b0}};
            phase_r     <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
            if (accept_s) begin
                for (int i = 10; i > 0; i--) dly_r[i] <= dly_r[i-1];
                dly_r[0] <= cond_in($signed(in_data));
                phase_r  <= ~phase_r;
            end
            if (in_valid && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (state_r == ST_ROUND) begin
                out_data_r <= conv_s;
            end
            out_valid_r <= (state_r == ST_ROUND);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_hb_decim2.sv
// Self-checking bench for hb_decim2: tap-sum reference model plus directed vectors with literal expectations.
module tb_hb_decim2;

    localparam int TB_SHIFT = 0;
    localparam longint H [0:10] = '{762, 0, -5488, 0, 37494, 65536, 37494, 0, -5488, 0, 762};
    localparam longint M = 8388607;
`ifdef HB_SAT_EN
    localparam longint SIGN_EXP = 8388607;
`else
    localparam longint SIGN_EXP = -6983681;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic [23:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    hb_decim2 #(.IN_SHIFT(TB_SHIFT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    longint hist [0:10];
    int     phase_m;
    longint exp_val_q[$];
    int     exp_cyc_q[$];
    longint last_out;
    int     busy_lo, busy_hi;
    longint ovr_m;
    int     cyc = 0;
    longint obs[$];

    function automatic longint cond_in(input logic [63:0] v);
        longint s;
        s = $signed(v) >>> TB_SHIFT;
        if (s > M) return M;
        if (s < -M - 1) return -M - 1;
        return s;
    endfunction

    function automatic longint conv_out(input longint r);
        longint w;
`ifdef HB_SAT_EN
        if (r > M) return M;
        if (r < -M - 1) return -M - 1;
        return r;
`else
        w = r & 64'hFF_FFFF;
        if (w > M) w = w - 64'd16777216;
        return w;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 11; i++) hist[i] = 0;
        phase_m = 0;
        exp_val_q.delete();
        exp_cyc_q.delete();
        last_out = 0;
        busy_lo = -1;
        busy_hi = -2;
        ovr_m = 0;
    endtask

    // Compare DUT outputs with the model each cycle, then feed this cycle's input to the model.
    always @(negedge clk) begin
        longint acc;
        bit     expv;
        cyc++;
        if (!rst) begin
            model_reset();
            chk("reset_out_valid", longint'(out_valid), 0);
            chk("reset_out_data", longint'($signed(out_data)), 0);
            chk("reset_busy", longint'(busy), 0);
            chk("reset_overrun", longint'(overrun), 0);
        end else begin
            expv = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            chk("out_valid", longint'(out_valid), longint'(expv));
            if (expv) begin
                last_out = exp_val_q.pop_front();
                void'(exp_cyc_q.pop_front());
            end
            chk("out_data", longint'($signed(out_data)), last_out);
            chk("busy", longint'(busy), longint'((cyc >= busy_lo) && (cyc <= busy_hi)));
            chk("overrun", longint'(overrun), ovr_m);
            if (out_valid) obs.push_back(longint'($signed(out_data)));
            if (in_valid) begin
                if ((cyc >= busy_lo) && (cyc <= busy_hi)) begin
                    ovr_m = 1;
                end else begin
                    for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
                    hist[0] = cond_in(in_data);
                    if (phase_m == 1) begin
                        acc = 0;
                        for (int i = 0; i < 11; i++) acc += H[i] * hist[i];
                        exp_val_q.push_back(conv_out((acc + 65536) >>> 17));
                        exp_cyc_q.push_back(cyc + 6);
                        busy_lo = cyc + 1;
                        busy_hi = cyc + 5;
                    end
                    phase_m = 1 - phase_m;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input int gap);
        in_data  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    longint odd_exp  [0:6] = '{762, -5488, 37494, 37494, -5488, 762, 0};
    longint even_exp [0:5] = '{0, 0, 65536, 0, 0, 0};
    logic [63:0] sign_vec [0:11];

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 64'd0;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();

        // Impulse, odd alignment
        obs.delete();
        send(64'd0, 100);
        send(64'd131072, 100);
        repeat (12) send(64'd0, 100);
        repeat (8) tick();
        chk("odd_count", obs.size(), 7);
        for (int i = 0; i < 7; i++) if (i < obs.size()) chk("odd_impulse", obs[i], odd_exp[i]);

        // Impulse, even alignment
        obs.delete();
        send(64'd131072, 100);
        repeat (11) send(64'd0, 100);
        repeat (8) tick();
        chk("even_count", obs.size(), 6);
        for (int i = 0; i < 6; i++) if (i < obs.size()) chk("even_impulse", obs[i], even_exp[i]);

        // DC at minimum spacing (accept while out_valid is high)
        obs.delete();
        repeat (16) send(64'd1000, 6);
        repeat (8) tick();
        chk("dc_count", obs.size(), 8);
        for (int i = 5; i < 8; i++) if (i < obs.size()) chk("dc_steady", obs[i], 1000);

        // Input saturation
        obs.delete();
        repeat (22) send(64'd1 << 40, 7);
        repeat (8) tick();
        chk("sat_count", obs.size(), 11);
        if (obs.size() > 0) chk("sat_steady", obs[obs.size()-1], M);

        // Worst-case sign pattern exercises output saturation / wrap
        sign_vec = '{64'd0, 64'd1 << 40, 64'd0, -64'sd8388607, 64'd0, 64'd1 << 40,
                     64'd1 << 40, 64'd1 << 40, 64'd0, -64'sd8388607, 64'd0, 64'd1 << 40};
        obs.delete();
        for (int i = 0; i < 12; i++) send(sign_vec[i], 7);
        repeat (8) tick();
        chk("sign_count", obs.size(), 6);
        if (obs.size() > 0) chk("sign_pattern", obs[obs.size()-1], SIGN_EXP);

        // Overrun: a strobe 3 clk after a start is dropped
        obs.delete();
        chk("ovr_before", longint'(overrun), 0);
        send(64'd11, 10);
        send(64'd22, 3);
        send(64'd99999, 3);
        send(64'd33, 10);
        send(64'd44, 10);
        repeat (8) tick();
        chk("ovr_count", obs.size(), 2);
        chk("ovr_set", longint'(overrun), 1);
        repeat (20) tick();
        chk("ovr_sticky", longint'(overrun), 1);

        // Reset during MAC1 aborts the sequence
        obs.delete();
        send(64'd131072, 10);
        in_data  = 64'd131072;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("rst_no_output", obs.size(), 0);
        chk("rst_out_data", longint'($signed(out_data)), 0);
        chk("rst_overrun", longint'(overrun), 0);
        rst = 1'b1;
        tick();
        send(64'd131072, 10);
        send(64'd131072, 10);
        repeat (8) tick();
        chk("post_rst_count", obs.size(), 1);
        if (obs.size() > 0) chk("post_rst_value", obs[0], 762);

        repeat (4) tick();
        chk("pending_outputs", exp_val_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
